// File: rtl/fpu_operand_sequencer.sv
// Queues IEEE-754 operand pairs, drives them to an external FPU, holds them for
// HOLD_CYCLES, then captures the FPU result. Optional result counter: FPU_SEQ_RESCNT_EN.
module fpu_operand_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned STATUS_W    = 4
) (
    input  logic                clock_100Khz,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_op_a,
    input  logic [31:0]         in_op_b,
    output logic [31:0]         fpu_op_a,
    output logic [31:0]         fpu_op_b,
    input  logic [31:0]         fpu_data,
    input  logic [STATUS_W-1:0] fpu_status,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [31:0]         res_data,
    output logic [STATUS_W-1:0] res_status,
    output logic                busy
`ifdef FPU_SEQ_RESCNT_EN
    ,
    output logic [15:0]         res_count
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [31:0]         op_a_q, op_a_d;
    logic [31:0]         op_b_q, op_b_d;
    logic                res_valid_q, res_valid_d;
    logic [31:0]         res_data_q, res_data_d;
    logic [STATUS_W-1:0] res_status_q, res_status_d;
    logic [63:0]         mem_q [DEPTH];
    logic [63:0]         head;
    logic                push;
    logic                pop;
`ifdef FPU_SEQ_RESCNT_EN
    logic [15:0]         res_cnt_q, res_cnt_d;
`endif

    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == ST_IDLE) && (count_q != '0);
    assign head     = mem_q[rd_ptr_q];

    // Payload storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clock_100Khz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_op_a, in_op_b};
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        hold_d       = hold_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_status_d = res_status_q;
`ifdef FPU_SEQ_RESCNT_EN
        res_cnt_d    = res_cnt_q;
`endif

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    op_a_d  = head[63:32];
                    op_b_d  = head[31:0];
                    hold_d  = HW'(HOLD_CYCLES - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (hold_q == '0) begin
                    res_data_d   = fpu_data;
                    res_status_d = fpu_status;
                    res_valid_d  = 1'b1;
                    state_d      = ST_OUTPUT;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            ST_OUTPUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef FPU_SEQ_RESCNT_EN
        if (res_valid_q && res_ready && (res_cnt_q != 16'hFFFF)) begin
            res_cnt_d = res_cnt_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clock_100Khz or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_q       <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_status_q <= '0;
`ifdef FPU_SEQ_RESCNT_EN
            res_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_q       <= hold_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_status_q <= res_status_d;
`ifdef FPU_SEQ_RESCNT_EN
            res_cnt_q    <= res_cnt_d;
`endif
        end
    end

    assign fpu_op_a   = op_a_q;
    assign fpu_op_b   = op_b_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_status = res_status_q;
    assign busy       = (state_q != ST_IDLE) || (count_q != '0);
`ifdef FPU_SEQ_RESCNT_EN
    assign res_count  = res_cnt_q;
`endif

endmodule
